elevator_ctrl: RTL

Parametrised single-car elevator controller, the next generation of our fixed 16-floor residential elevator. It adds configurable floor count, restricted-floor threshold, multi-cycle travel and door timing, collective (SCAN) dispatch with direction persistence, and an emergency-stop hold. It sits between the car-call buttons and sensors and the floor display and drive outputs; display decoding stays outside this block.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/call_register.sv | 66 ++++++
 rtl/elevator_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_pkg                                                         |
// | Shared FSM state encoding and travel-direction constants.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/call_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | call_register                                                        |
// | Card-gated car-call latch with clear-on-arrival and position flags.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module call_register
  import elevator_pkg::*;
#(
  parameter int N_FLOORS  = 16,
  parameter int RES_FLOOR = 6,
  parameter int FW        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] i_call_btn,
  input  logic                i_card,
  input  logic [FW-1:0]       i_floor,
  input  logic                i_block_here,
  input  logic                i_clr_en,
  input  logic [FW-1:0]       i_clr_floor,
  output logic [N_FLOORS-1:0] o_req,
  output logic                o_here,
  output logic                o_above,
  output logic                o_below,
  output logic                o_press_here
);

  logic [N_FLOORS-1:0] r_req;
  logic [N_FLOORS-1:0] w_ok;
  logic [N_FLOORS-1:0] w_set;
  logic [N_FLOORS-1:0] w_clr;

  always_comb begin
    w_ok         = '0;
    w_set        = '0;
    w_clr        = '0;
    o_here       = 1'b0;
    o_above      = 1'b0;
    o_below      = 1'b0;
    o_press_here = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      w_ok[i] = i_call_btn[i] && ((i < RES_FLOOR) || i_card);
      if (FW'(i) == i_floor) begin
        o_here       = r_req[i];
        o_press_here = w_ok[i];
        // a press at the open door only extends the dwell
        w_set[i]     = w_ok[i] && !i_block_here;
      end else begin
        w_set[i] = w_ok[i];
      end
      if (FW'(i) > i_floor) o_above = o_above | r_req[i];
      if (FW'(i) < i_floor) o_below = o_below | r_req[i];
      if (i_clr_en && (FW'(i) == i_clr_floor)) w_clr[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_req <= '0;
    else        r_req <= (r_req | w_set) & ~w_clr;
  end

  assign o_req = r_req;

endmodule
`default_nettype wire

// File: rtl/elevator_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_ctrl                                                        |
// | Single-car SCAN elevator controller with door timing and e-stop.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int  N_FLOORS      = 16,
  parameter int  RES_FLOOR     = 6,
  parameter int  TRAVEL_CYCLES = 4,
  parameter int  DOOR_CYCLES   = 8,
  localparam int FW            = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic                card,
  input  logic                door_sensor,
  input  logic                door_hold,
  input  logic                door_close,
  input  logic                estop,
  output logic [N_FLOORS-1:0] call_led,
  output logic [FW-1:0]       floor,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic                arrive
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  state_t              r_state, r_saved, w_state, w_saved, w_cur;
  logic [FW-1:0]       r_floor, w_floor, w_step_floor, w_clr_floor;
  logic [TW-1:0]       r_travel, w_travel;
  logic [DW-1:0]       r_dwell, w_dwell;
  logic                r_dir, w_dir;
  logic                r_arrive, w_arrive;
  logic                w_clr_en, w_term, w_hit, w_arrive_now;
  logic [N_FLOORS-1:0] w_req;
  logic                w_here, w_above, w_below, w_press_here;

  call_register #(
    .N_FLOORS  (N_FLOORS),
    .RES_FLOOR (RES_FLOOR),
    .FW        (FW)
  ) u_call_register (
    .clk          (clock),
    .rst_n        (clear),
    .i_call_btn   (call_btn),
    .i_card       (card),
    .i_floor      (r_floor),
    .i_block_here (r_state == DOOR),
    .i_clr_en     (w_clr_en),
    .i_clr_floor  (w_clr_floor),
    .o_req        (w_req),
    .o_here       (w_here),
    .o_above      (w_above),
    .o_below      (w_below),
    .o_press_here (w_press_here)
  );

  assign w_step_floor = r_dir ? (r_floor + FW'(1)) : (r_floor - FW'(1));
  assign w_term       = (r_travel == TW'(TRAVEL_CYCLES - 1));

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FW'(i) == w_step_floor) w_hit = w_req[i];
    end
  end

  assign w_arrive_now = (r_state == MOVE) && w_term && w_hit;
  // a halted car resumes by acting as its saved state on the release edge
  assign w_cur        = (r_state == HALT) ? r_saved : r_state;

  always_comb begin
    w_state     = r_state;
    w_saved     = r_saved;
    w_floor     = r_floor;
    w_dir       = r_dir;
    w_travel    = r_travel;
    w_dwell     = r_dwell;
    w_arrive    = 1'b0;
    w_clr_en    = 1'b0;
    w_clr_floor = r_floor;
    if (estop && !w_arrive_now) begin
      w_state = HALT;
      w_saved = w_cur;
    end else begin
      w_state = w_cur;
      case (w_cur)
        IDLE: begin
          if (w_here) begin
            w_state  = DOOR;
            w_dwell  = DW'(DOOR_CYCLES - 1);
            w_clr_en = 1'b1;
            w_arrive = 1'b1;
          end else if (w_above) begin
            w_state  = MOVE;
            w_dir    = UP;
            w_travel = '0;
          end else if (w_below) begin
            w_state  = MOVE;
            w_dir    = DOWN;
            w_travel = '0;
          end
        end
        MOVE: begin
          if (w_term) begin
            w_travel = '0;
            w_floor  = w_step_floor;
            if (w_hit) begin
              w_state     = DOOR;
              w_dwell     = DW'(DOOR_CYCLES - 1);
              w_clr_en    = 1'b1;
              w_clr_floor = w_step_floor;
              w_arrive    = 1'b1;
            end
          end else begin
            w_travel = r_travel + TW'(1);
          end
        end
        DOOR: begin
          if (door_sensor || door_hold || w_press_here) begin
            w_dwell = DW'(DOOR_CYCLES - 1);
          end else if (r_dwell == '0) begin
            w_travel = '0;
            if (r_dir ? w_above : w_below) begin
              w_state = MOVE;
            end else if (r_dir ? w_below : w_above) begin
              w_state = MOVE;
              w_dir   = ~r_dir;
            end else begin
              w_state = IDLE;
            end
          end else if (door_close) begin
            w_dwell = '0;
          end else begin
            w_dwell = r_dwell - DW'(1);
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state  <= IDLE;
      r_saved  <= IDLE;
      r_floor  <= '0;
      r_dir    <= UP;
      r_travel <= '0;
      r_dwell  <= '0;
      r_arrive <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_saved  <= w_saved;
      r_floor  <= w_floor;
      r_dir    <= w_dir;
      r_travel <= w_travel;
      r_dwell  <= w_dwell;
      r_arrive <= w_arrive;
    end
  end

  assign call_led  = w_req;
  assign floor     = r_floor;
  assign dir_up    = r_dir;
  assign moving    = (r_state == MOVE);
  assign door_open = (r_state == DOOR) || ((r_state == HALT) && (r_saved == DOOR));
  assign arrive    = r_arrive;

endmodule
`default_nettype wire
